subblock_interleaver: RTL

Rate-matching sub-block interleaver that sits directly downstream of the parallel tail-biting convolutional encoder. It drains the encoder's three coded-stream FIFOs (d0/d1/d2) for one code block and stores each stream row-wise in a 32-column matrix. It then reads each matrix out column-wise in the TBCC inter-column permutation order, emitting the three interleaved streams as bytes to the bit-collection stage.

---
 rtl/subblock_pkg.sv | 25 ++
 rtl/subblock_bit_ram.sv | 31 +++
 rtl/subblock_interleaver.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/subblock_pkg.sv
// rtl/subblock_pkg.sv - shared types and constants for the sub-block interleaver
// Contents: FSM state enum, block size constants, TBCC inter-column permutation.
package subblock_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DRAIN,
    ST_PERMUTE
  } state_t;

  localparam int NB_SMALL = 132;   // bytes per stream, K=1056
  localparam int NB_LARGE = 768;   // bytes per stream, K=6144
  localparam int R_SMALL  = 33;    // matrix rows, K=1056
  localparam int R_LARGE  = 192;   // matrix rows, K=6144

  // Inter-column permutation: output column m reads matrix column P[m].
  localparam logic [4:0] P [32] = '{
    5'd1,  5'd17, 5'd9,  5'd25, 5'd5,  5'd21, 5'd13, 5'd29,
    5'd3,  5'd19, 5'd11, 5'd27, 5'd7,  5'd23, 5'd15, 5'd31,
    5'd0,  5'd16, 5'd8,  5'd24, 5'd4,  5'd20, 5'd12, 5'd28,
    5'd2,  5'd18, 5'd10, 5'd26, 5'd6,  5'd22, 5'd14, 5'd30
  };

endpackage

// File: rtl/subblock_bit_ram.sv
// rtl/subblock_bit_ram.sv - 192x32 matrix store with byte write enables, sync read
// Ports:
//   clk          clock
//   we, be       write strobe and per-byte lane enables
//   waddr, wdata write row address and data (lane i = columns 8i..8i+7)
//   re, raddr    read strobe and row address
//   rdata        row word, valid the cycle after re; held while re is low
module subblock_bit_ram (
  input  logic        clk,
  input  logic        we,
  input  logic [3:0]  be,
  input  logic [7:0]  waddr,
  input  logic [31:0] wdata,
  input  logic        re,
  input  logic [7:0]  raddr,
  output logic [31:0] rdata
);

  logic [31:0] mem [192];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
    // Holding rdata when re is low lets the caller freeze the read pipeline.
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/subblock_interleaver.sv
// rtl/subblock_interleaver.sv - TBCC sub-block interleaver for three coded streams
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   computation_done     encoder pulse: block ready in its FIFOs
//   length_in            0 = K=1056, 1 = K=6144
//   q0..q2               encoder FIFO data, valid the cycle after rdreq_subblock
//   rdreq_subblock       FIFO read strobe
//   v0..v2, out_valid    interleaved output bytes (bit 0 first) and valid
//   out_ready            downstream accept
//   block_start/end      first / last byte of the block
//   busy, err_overrun    block in progress; sticky computation_done-while-busy
module subblock_interleaver
  import subblock_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       computation_done,
  input  logic       length_in,
  input  logic [7:0] q0,
  input  logic [7:0] q1,
  input  logic [7:0] q2,
  output logic       rdreq_subblock,
  output logic [7:0] v0,
  output logic [7:0] v1,
  output logic [7:0] v2,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       block_start,
  output logic       block_end,
  output logic       busy,
  output logic       err_overrun
);

  state_t state, state_n;
  logic       len_r;
  logic [9:0] load_cnt;
  logic       wr_en;
  logic [9:0] wr_byte;
  logic [8:0] row_cnt;
  logic [4:0] m_cnt;
  logic [2:0] bit_cnt;
  logic       issue_done;
  logic       rd_valid;
  logic [4:0] rd_col;
  logic [2:0] rd_bit;
  logic [6:0] acc0, acc1, acc2;
  logic [9:0] byte_cnt;
  logic [31:0] rdata0, rdata1, rdata2;

  logic [9:0] nb;
  logic [8:0] r_last;
  logic       stall, issue, take, load_hold, accepted, last_hs;
  logic       b0, b1, b2;

  assign nb     = len_r ? 10'(NB_LARGE) : 10'(NB_SMALL);
  assign r_last = len_r ? 9'(R_LARGE - 1) : 9'(R_SMALL - 1);

  assign rdreq_subblock = (state == ST_LOAD);
  assign busy           = (state != ST_IDLE);

  // A full, unaccepted holding register freezes every pipeline stage.
  assign stall     = out_valid && !out_ready;
  // Reads start in DRAIN: row 0 was written long before the final write lands.
  assign issue     = ((state == ST_DRAIN) || (state == ST_PERMUTE)) && !issue_done && !stall;
  assign take      = rd_valid && !stall;
  assign load_hold = take && (rd_bit == 3'd7);
  assign accepted  = out_valid && out_ready;
  assign last_hs   = accepted && block_end;

  assign b0 = rdata0[rd_col];
  assign b1 = rdata1[rd_col];
  assign b2 = rdata2[rd_col];

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:    if (computation_done) state_n = ST_LOAD;
      ST_LOAD:    if (load_cnt == nb - 10'd1) state_n = ST_DRAIN;
      ST_DRAIN:   state_n = ST_PERMUTE;
      ST_PERMUTE: if (last_hs) state_n = ST_IDLE;
      default:    state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      len_r       <= 1'b0;
      load_cnt    <= '0;
      wr_en       <= 1'b0;
      wr_byte     <= '0;
      row_cnt     <= '0;
      m_cnt       <= '0;
      bit_cnt     <= '0;
      issue_done  <= 1'b0;
      rd_valid    <= 1'b0;
      rd_col      <= '0;
      rd_bit      <= '0;
      acc0        <= '0;
      acc1        <= '0;
      acc2        <= '0;
      byte_cnt    <= '0;
      v0          <= '0;
      v1          <= '0;
      v2          <= '0;
      out_valid   <= 1'b0;
      block_start <= 1'b0;
      block_end   <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      state <= state_n;
      if (computation_done && (state != ST_IDLE)) err_overrun <= 1'b1;

      // FIFO data arrives one cycle after the strobe; carry the byte index along.
      wr_en   <= rdreq_subblock;
      wr_byte <= load_cnt;

      if ((state == ST_IDLE) && computation_done) begin
        len_r      <= length_in;
        load_cnt   <= '0;
        row_cnt    <= '0;
        m_cnt      <= '0;
        bit_cnt    <= '0;
        issue_done <= 1'b0;
        rd_valid   <= 1'b0;
        byte_cnt   <= '0;
      end
      if (state == ST_LOAD) load_cnt <= load_cnt + 10'd1;

      if (issue) begin
        rd_col  <= P[m_cnt];
        rd_bit  <= bit_cnt;
        bit_cnt <= bit_cnt + 3'd1;
        if (row_cnt == r_last) begin
          row_cnt <= '0;
          m_cnt   <= m_cnt + 5'd1;
          if (m_cnt == 5'd31) issue_done <= 1'b1;
        end else begin
          row_cnt <= row_cnt + 9'd1;
        end
      end
      if (!stall) rd_valid <= issue;

      // LSB-first packing: after seven shifts acc[0] holds the earliest bit.
      if (take) begin
        acc0 <= {b0, acc0[6:1]};
        acc1 <= {b1, acc1[6:1]};
        acc2 <= {b2, acc2[6:1]};
      end

      if (load_hold) begin
        v0          <= {b0, acc0};
        v1          <= {b1, acc1};
        v2          <= {b2, acc2};
        out_valid   <= 1'b1;
        block_start <= (byte_cnt == 10'd0);
        block_end   <= (byte_cnt == nb - 10'd1);
        byte_cnt    <= byte_cnt + 10'd1;
      end else if (accepted) begin
        out_valid   <= 1'b0;
        block_start <= 1'b0;
        block_end   <= 1'b0;
      end
    end
  end

  logic [3:0]  wr_be;
  logic [7:0]  wr_row;
  assign wr_be  = 4'b0001 << wr_byte[1:0];
  assign wr_row = wr_byte[9:2];

  subblock_bit_ram u_ram0 (
    .clk(clk), .we(wr_en), .be(wr_be), .waddr(wr_row), .wdata({4{q0}}),
    .re(issue), .raddr(row_cnt[7:0]), .rdata(rdata0)
  );
  subblock_bit_ram u_ram1 (
    .clk(clk), .we(wr_en), .be(wr_be), .waddr(wr_row), .wdata({4{q1}}),
    .re(issue), .raddr(row_cnt[7:0]), .rdata(rdata1)
  );
  subblock_bit_ram u_ram2 (
    .clk(clk), .we(wr_en), .be(wr_be), .waddr(wr_row), .wdata({4{q2}}),
    .re(issue), .raddr(row_cnt[7:0]), .rdata(rdata2)
  );

endmodule
